imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined RISC-V immediate generator for RV32/RV64 decode. Accepts one 32-bit instruction per cycle over a valid/ready handshake and produces the XLEN-wide immediate, an immediate-type code, an illegal flag and a pass-through tag. Output is registered, with an optional 2-entry skid buffer so the upstream ready does not depend combinationally on downstream ready. Sits between fetch/IF-ID and the decode/register-read stage.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; any other value is an elaboration error.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register stage with combinational in_ready.
TAG_W, 8, width of the side-band tag carried alongside each instruction (e.g. PC index or ROB id).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_inst  in  32  instruction word
in_tag  in  TAG_W  side-band tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_imm  out  XLEN  sign/zero-extended immediate
out_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shift amount)
out_illegal  out  1  opcode/encoding not legal for this XLEN
out_tag  out  TAG_W  tag of the result

Behaviour:
- Transfer in: in_valid && in_ready on a rising edge. Transfer out: out_valid && out_ready.
- Latency: exactly 1 cycle from accept to out_valid when the output slot is free. Results leave in acceptance order; no loss, no duplication.
- Reset (async, rst_n low): out_valid=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0, state EMPTY. Reset mid-operation discards all held entries immediately. in_ready=1 once rst_n is high.
- SKID=1 state machine, with a registered in_ready equal to (state != TWO):
  - EMPTY: on accept, go to ONE.
  - ONE: on accept without drain, go to TWO (the new entry goes to the skid register). On drain without accept, go to EMPTY. On accept and drain together, stay in ONE with the output register reloaded.
  - TWO: in_ready=0. On drain, the skid entry moves to the output register and the state goes to ONE.
- SKID=0: in_ready = !out_valid || out_ready. On accept, load the output register. On drain without accept, clear out_valid.
- out_* are held stable while out_valid && !out_ready.
- Decode by opcode inst[6:0], with the sign bit taken from inst[31] and extended to XLEN:
  - 0110111 LUI and 0010111 AUIPC: type U, imm = {inst[31:12], 12'b0}. Sign-extended for both (RV64I semantics).
  - 1101111 JAL: type J, imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 1100011 BRANCH: type B, imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 1100111 JALR, 0000011 LOAD, 0001111 MISC-MEM: type I, imm = inst[31:20].
  - 0100011 STORE: type S, imm = {inst[31:25], inst[11:7]}.
  - 0010011 OP-IMM:
    - funct3 001/101: type SH, imm = zero-extended shamt. shamt is inst[25:20] for XLEN=64 and inst[24:20] for XLEN=32. For XLEN=32, inst[25]=1 sets illegal.
    - Other funct3: type I.
  - 0011011 OP-IMM-32: XLEN=64 only.
    - funct3 001/101: type SH, imm = inst[24:20]; inst[25]=1 sets illegal.
    - Otherwise: type I.
    - For XLEN=32: type NONE, imm 0, illegal.
  - 1110011 SYSTEM:
    - funct3[2]=1: type Z, imm = zero-extended inst[19:15].
    - Otherwise: type I.
  - 0110011 OP: type NONE, imm 0, legal.
  - 0111011 OP-32: legal only when XLEN=64.
  - Any other opcode: type NONE, imm 0, illegal=1.

Decomposition:
- Package imm_pkg: opcode localparams, imm_type_e enum (3-bit, values as above), and the XLEN legality check.
- Sub-module imm_decode: purely combinational, parameter XLEN, maps inst to {imm, type, illegal}.
- imm_gen_pipe: instantiates imm_decode once on in_inst and owns the handshake/skid registers.

Test Plan:
- XLEN=64, inst 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, imm 0xFFFF_FFFF_FFFF_FFFF, type I, illegal 0, tag echoed.
- XLEN=64, inst 0x800000B7 (LUI) -> imm 0xFFFF_FFFF_8000_0000, type U. XLEN=32 -> imm 0x8000_0000.
- inst 0x03F09093 (slli x1,x1,63) -> XLEN=64: type SH, imm 63, illegal 0. XLEN=32: illegal 1, imm 31.
- inst 0x3401D073 (csrrwi x0,0x340,3) -> type Z, imm 3. Inst 0x0000007F -> type NONE, imm 0, illegal 1.
- SKID=1, out_ready=0, three back-to-back valid instructions tagged 1,2,3:
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after the second accept.
  - Releasing out_ready delivers tags 1,2,3 in order, one per cycle, with outputs held stable while stalled.
- With state TWO, pulse rst_n low mid-cycle -> out_valid=0 asynchronously. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-type codes and pipeline state encoding
// for the RISC-V immediate generator.
package imm_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6,
        IMM_SH   = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate decoder: maps an instruction word to its
// XLEN-wide immediate, immediate-type code and an illegal-encoding flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode: XLEN must be 32 or 64");
    end

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        shift_op;
    logic [31:0] imm32;
    imm_type_e   typ;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign shift_op = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate fits in 32 bits already sign- or zero-extended, so one
    // final sign extension from bit 31 covers both RV32 and RV64.
    always_comb begin
        imm32   = '0;
        typ     = IMM_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                typ   = IMM_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                typ   = IMM_J;
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_BRANCH: begin
                typ   = IMM_B;
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM: begin
                typ   = IMM_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                typ   = IMM_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_OP_IMM: begin
                if (shift_op) begin
                    typ = IMM_SH;
                    if (IS64) begin
                        imm32 = {26'b0, inst[25:20]};
                    end else begin
                        imm32   = {27'b0, inst[24:20]};
                        illegal = inst[25];
                    end
                end else begin
                    typ   = IMM_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                if (!IS64) begin
                    illegal = 1'b1;
                end else if (shift_op) begin
                    typ     = IMM_SH;
                    imm32   = {27'b0, inst[24:20]};
                    illegal = inst[25];
                end else begin
                    typ   = IMM_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    typ   = IMM_Z;
                    imm32 = {27'b0, inst[19:15]};
                end else begin
                    typ   = IMM_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_OP: begin
                illegal = 1'b0;
            end
            OPC_OP_32: begin
                illegal = !IS64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm      = XLEN'($signed(imm32));
    assign imm_type = typ;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes one instruction per cycle behind a
// valid/ready handshake, with an optional 2-entry skid buffer on the output.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int SKID  = 1,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int ENT_W = XLEN + 3 + 1 + TAG_W;

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_type;
    logic             dec_illegal;
    logic [ENT_W-1:0] in_entry;
    logic [ENT_W-1:0] out_q;
    logic             accept;
    logic             drain;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst     (in_inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign in_entry = {dec_imm, dec_type, dec_illegal, in_tag};
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign {out_imm, out_type, out_illegal, out_tag} = out_q;

    if (SKID != 0) begin : g_skid
        pipe_state_e      state_q;
        pipe_state_e      state_d;
        logic [ENT_W-1:0] skid_q;
        logic             ready_q;
        logic             load_out;
        logic             load_skid;
        logic             pop_skid;

        // in_ready is registered from the next state so it never depends on out_ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_EMPTY;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != ST_TWO);
            end
        end

        always_comb begin
            state_d   = state_q;
            load_out  = 1'b0;
            load_skid = 1'b0;
            pop_skid  = 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d  = ST_ONE;
                        pop_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q  <= '0;
                skid_q <= '0;
            end else begin
                if (load_out) begin
                    out_q <= in_entry;
                end else if (pop_skid) begin
                    out_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_entry;
                end
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = (state_q != ST_EMPTY);
    end else begin : g_single
        logic valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                out_q   <= '0;
            end else if (accept) begin
                valid_q <= 1'b1;
                out_q   <= in_entry;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end

        assign in_ready  = !valid_q || out_ready;
        assign out_valid = valid_q;
    end

endmodule
